// File: rtl/op_route_responder.sv
// ============================================================================
//  op_route_responder
//  Start/done operation responder: base-2/10/12 arithmetic with a latency
//  chosen by the selected condition and the opcode family.
//  Optional: OP_RESP_STATS_EN adds stat_ops / stat_busy_cyc / stat_drops.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module op_route_responder #(
   parameter int B2_LAT_BIN  = 1,
   parameter int B2_LAT_DEC  = 8,
   parameter int B2_LAT_DUO  = 6,
   parameter int B10_LAT_DEC = 1,
   parameter int B10_LAT_BIN = 6,
   parameter int B10_LAT_DUO = 6,
   parameter int B12_LAT_DUO = 1,
   parameter int B12_LAT_BIN = 6,
   parameter int B12_LAT_DEC = 8,
   parameter int ROUTE_OVH   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  cond_sel,
   input  logic [3:0]  opcode,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        err
`ifdef OP_RESP_STATS_EN
  ,output logic [31:0] stat_ops,
   output logic [31:0] stat_busy_cyc,
   output logic [31:0] stat_drops
`endif
);

   localparam logic [3:0] c_op_bin_add   = 4'd0;
   localparam logic [3:0] c_op_bin_sub   = 4'd1;
   localparam logic [3:0] c_op_bin_mul   = 4'd2;
   localparam logic [3:0] c_op_dec_add   = 4'd3;
   localparam logic [3:0] c_op_dec_sub   = 4'd4;
   localparam logic [3:0] c_op_dec_mul10 = 4'd5;
   localparam logic [3:0] c_op_duo_add12 = 4'd6;
   localparam logic [3:0] c_op_duo_sub12 = 4'd7;
   localparam logic [3:0] c_op_duo_mul3  = 4'd8;

   localparam logic [1:0] c_fam_bin = 2'd0;
   localparam logic [1:0] c_fam_dec = 2'd1;
   localparam logic [1:0] c_fam_duo = 2'd2;
   localparam logic [1:0] c_fam_bad = 2'd3;

   localparam logic [16:0] c_m_dec = 17'd10000;
   localparam logic [16:0] c_m_duo = 17'd20736;

   function automatic logic [7:0] f_clamp(input int x);
      return (x < 1) ? 8'd1 : 8'(x);
   endfunction

   localparam int c_min_duo = (B2_LAT_DUO < B10_LAT_DUO) ? B2_LAT_DUO : B10_LAT_DUO;

   localparam logic [7:0] c_l_b2_bin  = f_clamp(B2_LAT_BIN);
   localparam logic [7:0] c_l_b2_dec  = f_clamp(B2_LAT_DEC);
   localparam logic [7:0] c_l_b2_duo  = f_clamp(B2_LAT_DUO);
   localparam logic [7:0] c_l_b10_bin = f_clamp(B10_LAT_BIN);
   localparam logic [7:0] c_l_b10_dec = f_clamp(B10_LAT_DEC);
   localparam logic [7:0] c_l_b10_duo = f_clamp(B10_LAT_DUO);
   localparam logic [7:0] c_l_b12_bin = f_clamp(B12_LAT_BIN);
   localparam logic [7:0] c_l_b12_dec = f_clamp(B12_LAT_DEC);
   localparam logic [7:0] c_l_b12_duo = f_clamp(B12_LAT_DUO);
   localparam logic [7:0] c_l_r_bin   = f_clamp(B2_LAT_BIN + ROUTE_OVH);
   localparam logic [7:0] c_l_r_dec   = f_clamp(B10_LAT_DEC + ROUTE_OVH);
   localparam logic [7:0] c_l_r3_duo  = f_clamp(c_min_duo + ROUTE_OVH);
   localparam logic [7:0] c_l_r4_duo  = f_clamp(B12_LAT_DUO + ROUTE_OVH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

   function automatic logic [1:0] f_family(input logic [3:0] op);
      if (op <= c_op_bin_mul)        return c_fam_bin;
      else if (op <= c_op_dec_mul10) return c_fam_dec;
      else if (op <= c_op_duo_mul3)  return c_fam_duo;
      else                           return c_fam_bad;
   endfunction

   function automatic logic [7:0] f_latency(input logic [2:0] cond, input logic [1:0] fam);
      logic [7:0] l;
      l = 8'd1;
      case (cond)
         3'd0: l = (fam == c_fam_bin) ? c_l_b2_bin  : (fam == c_fam_dec) ? c_l_b2_dec  : c_l_b2_duo;
         3'd1: l = (fam == c_fam_bin) ? c_l_b10_bin : (fam == c_fam_dec) ? c_l_b10_dec : c_l_b10_duo;
         3'd2: l = (fam == c_fam_bin) ? c_l_b12_bin : (fam == c_fam_dec) ? c_l_b12_dec : c_l_b12_duo;
         3'd3: l = (fam == c_fam_bin) ? c_l_r_bin   : (fam == c_fam_dec) ? c_l_r_dec   : c_l_r3_duo;
         3'd4: l = (fam == c_fam_bin) ? c_l_r_bin   : (fam == c_fam_dec) ? c_l_r_dec   : c_l_r4_duo;
         default: l = 8'd1;
      endcase
      return l;
   endfunction

   // Remainder by comparison against the multiples of 1000 (operand < 10000)
   function automatic logic [15:0] f_mod1000(input logic [15:0] a);
      logic [15:0] m;
      logic        found;
      m     = a;
      found = 1'b0;
      for (int k = 9; k >= 1; k--) begin
         if (!found && a >= 16'(k * 1000)) begin
            m     = a - 16'(k * 1000);
            found = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic logic [15:0] f_compute(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] m;
      logic [15:0] r;
      s = {1'b0, a} + {1'b0, b};
      m = '0;
      r = '0;
      case (op)
         c_op_bin_add:   r = a + b;
         c_op_bin_sub:   r = a - b;
         c_op_bin_mul:   r = a * b;
         c_op_dec_add:   r = (s >= c_m_dec) ? 16'(s - c_m_dec) : 16'(s);
         c_op_dec_sub:   r = (a >= b) ? a - b : a - b + 16'(c_m_dec);
         c_op_dec_mul10: begin
            m = f_mod1000(a);
            r = (m << 3) + (m << 1);
         end
         c_op_duo_add12: r = (s >= c_m_duo) ? 16'(s - c_m_duo) : 16'(s);
         c_op_duo_sub12: r = (a >= b) ? a - b : a - b + 16'(c_m_duo);
         c_op_duo_mul3: begin
            s = {1'b0, a} + {a, 1'b0};
            if (s >= c_m_duo) s = s - c_m_duo;
            if (s >= c_m_duo) s = s - c_m_duo;
            r = 16'(s);
         end
         default:        r = '0;
      endcase
      return r;
   endfunction

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [2:0]  r_cond;
   logic [3:0]  r_op;
   logic [15:0] r_a;
   logic [15:0] r_b;

   // Live inputs at acceptance, latched copies while the operation runs
   logic        w_idle;
   logic [2:0]  w_cond;
   logic [3:0]  w_op;
   logic [15:0] w_a;
   logic [15:0] w_b;
   logic [1:0]  w_fam;
   logic        w_err;
   logic [7:0]  w_lat;
   logic [15:0] w_res;

   always_comb begin
      w_idle = (r_state == S_IDLE);
      w_cond = w_idle ? cond_sel : r_cond;
      w_op   = w_idle ? opcode   : r_op;
      w_a    = w_idle ? op_a     : r_a;
      w_b    = w_idle ? op_b     : r_b;
      w_fam  = f_family(w_op);
      w_err  = (w_cond > 3'd4) || (w_fam == c_fam_bad) ||
               ((w_fam == c_fam_dec) && ({1'b0, w_a} >= c_m_dec || {1'b0, w_b} >= c_m_dec)) ||
               ((w_fam == c_fam_duo) && ({1'b0, w_a} >= c_m_duo || {1'b0, w_b} >= c_m_duo));
      w_lat  = w_err ? 8'd1 : f_latency(w_cond, w_fam);
      w_res  = w_err ? 16'd0 : f_compute(w_op, w_a, w_b);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_cond  <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cond <= cond_sel;
                  r_op   <= opcode;
                  r_a    <= op_a;
                  r_b    <= op_b;
                  busy   <= 1'b1;
                  if (w_lat == 8'd1) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     result  <= w_res;
                     err     <= w_err;
                  end else begin
                     r_cnt   <= w_lat - 8'd1;
                     r_state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               r_cnt <= r_cnt - 8'd1;
               if (r_cnt == 8'd1) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
                  result  <= w_res;
                  err     <= w_err;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef OP_RESP_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_ops      <= '0;
         stat_busy_cyc <= '0;
         stat_drops    <= '0;
      end else begin
         if (done)          stat_ops      <= stat_ops + 32'd1;
         if (busy)          stat_busy_cyc <= stat_busy_cyc + 32'd1;
         if (start && busy) stat_drops    <= stat_drops + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/op_route_responder.md
# op_route_responder

Execution-side responder for the benchmark start/done operation protocol. It accepts one operation per `start` pulse (condition, opcode, two 16-bit operands) and computes a base-2, base-10 or base-12 result. It returns `done` with the result after a latency set by the selected condition and the opcode's family. It stands in for the router under test wherever a cycle-accurate latency model with real results is required.

## Interface
- `B2_LAT_BIN`, 1: Base2 condition, binary-family latency (cycles)
- `B2_LAT_DEC`, 8: Base2 condition, decimal-family latency
- `B2_LAT_DUO`, 6: Base2 condition, duodecimal-family latency
- `B10_LAT_DEC`, 1 / `B10_LAT_BIN`, 6 / `B10_LAT_DUO`, 6: Base10 condition latencies
- `B12_LAT_DUO`, 1 / `B12_LAT_BIN`, 6 / `B12_LAT_DEC`, 8: Base12 condition latencies
- `ROUTE_OVH`, 0: extra cycles added for router conditions 3 and 4
- `clk` in 1: clock; one clock domain
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: request pulse; sampled only when `busy`=0
- `cond_sel` in 3: 0=Base2, 1=Base10, 2=Base12, 3=Router(2&10), 4=Router(2&10&12)
- `opcode` in 4: `OP_*` codes from `common_opcodes.vh`
- `op_a`, `op_b` in 16 each: operands
- `busy` out 1: operation in flight
- `done` out 1: one-cycle completion pulse
- `result` out 16: result; held until the next accepted start
- `err` out 1: error for the last operation; valid with `done`, held

## Operation
- Family: BIN = `OP_BIN_ADD/SUB/MUL`; DEC = `OP_DEC_ADD/SUB/MUL10`; DUO = `OP_DUO_ADD12/SUB12/MUL3`. Any other opcode is illegal.
- Latency L:
  - cond 0–2 use the matching parameter.
  - cond 3: BIN uses `B2_LAT_BIN`, DEC uses `B10_LAT_DEC`, DUO uses min(`B2_LAT_DUO`,`B10_LAT_DUO`); then add `ROUTE_OVH`.
  - cond 4: each family uses its native latency (`B2_LAT_BIN`/`B10_LAT_DEC`/`B12_LAT_DUO`), plus `ROUTE_OVH`.
  - L below 1 is clamped to 1. L is held in an 8-bit counter, so parameters must be ≤255.
- Arithmetic. Operands and opcode are latched at acceptance.
  - BIN_ADD/SUB: (a±b) mod 2^16. BIN_MUL: low 16 bits of a*b.
  - DEC (M=10000):
    - ADD: a+b, minus M if ≥M.
    - SUB: a≥b ? a−b : a−b+M.
    - MUL10: (a mod 1000)*10, with mod 1000 done by comparison against multiples of 1000.
  - DUO (M=20736):
    - ADD12: a+b, minus M if ≥M.
    - SUB12: a≥b ? a−b : a−b+M.
    - MUL3: 3a, reduced by at most two conditional subtractions of M.
  - DEC/DUO operand ≥M, illegal opcode, or `cond_sel` 5–7: `err`=1, `result`=0, L=1.
- FSM states:
  - IDLE: on `start` latch inputs, compute L; go to DONE if L=1, else load counter with L−1 and go to EXEC.
  - EXEC: decrement the counter; at 1 go to DONE.
  - DONE: `done`=1, update `result`/`err`; next state IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `err`=0, state IDLE, counter 0.
- Start accepted at edge t → `busy`=1 from t+1 through the `done` cycle inclusive. `done` is high exactly in cycle t+L, and `result`/`err` are valid in that same cycle.
- `busy` returns to 0 in the cycle after `done`. The minimum accepted start spacing is L+1 cycles.
- `start` while `busy`=1, including the DONE cycle, is ignored. Latched inputs and timing are unchanged.
- Input changes after acceptance have no effect.
- `rst_n`=0 mid-operation: return to IDLE at the next edge, no `done` pulse, outputs reset.

## Configuration
- `OP_RESP_STATS_EN` defined adds three 32-bit outputs `stat_ops`, `stat_busy_cyc`, `stat_drops`, all reset to 0:
  - `stat_ops` increments per `done`.
  - `stat_busy_cyc` increments per cycle with `busy`=1.
  - `stat_drops` increments per `start` ignored while busy.
  - The counters wrap at 2^32.
- Undefined: these ports and their logic are absent, and all other behaviour is identical.

## Test plan
- cond 0, `OP_BIN_ADD`, a=1000, b=1234, start at edge t → `done` at t+1, `result`=2234, `err`=0; `busy` high in cycle t+1 only.
- cond 1, `OP_BIN_ADD`, same operands → `done` at t+6, `result`=2234. Repeat with cond 4 → `done` at t+1.
- cond 2, `OP_DEC_SUB`, a=1234, b=9000 → `result`=2234 at t+8. cond 4, `OP_DEC_MUL10`, a=4095 → `result`=950 at t+1. cond 3, `OP_DUO_MUL3`, a=20000 → `result`=18528 at t+6.
- cond 4, `OP_DUO_ADD12`, a=25000 → `err`=1, `result`=0, `done` at t+1. cond 6 with any op → same response.
- cond 0, `OP_DEC_ADD`, a=2345, b=6789; second `start` pulsed at t+3 → single `done` at t+8 with `result`=9134; `stat_drops`=1 when `OP_RESP_STATS_EN` is defined.
- cond 2, `OP_BIN_MUL`; `rst_n` low at t+3 → no `done`, all outputs 0. A new start at t+6 completes normally.
